// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between port 0 (CPU) and port 1 (DMA); result registered one cycle later.
// Define ALU_ARB_PRIO_EN for fixed port-0 priority with a MAX_WAIT starvation guard (default build: round-robin ties).

module alu #(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  input  logic [3:0]           op,
  output logic [WORD_SIZE-1:0] c,
  output logic                 compare
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_TCP = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_DEC = 4'd10;
  localparam logic [3:0] OP_LHI = 4'd11;
  localparam logic [WORD_SIZE-1:0] ONE = 1;

  always_comb begin
    c = '0;
    case (op)
      OP_ADD: c = a + b;
      OP_SUB: c = a - b;
      OP_TCP: c = ~a + ONE;
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_XOR: c = a ^ b;
      OP_NOT: c = ~a;
      OP_SHL: c = a << 1;
      OP_SHR: c = a >> 1;
      OP_INC: c = a + ONE;
      OP_DEC: c = a - ONE;
      // Low half of b moves into the upper half of the word.
      OP_LHI: c = b << (WORD_SIZE / 2);
      default: c = '0;
    endcase
  end

  assign compare = (a == b);
endmodule

module alu_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [3:0]           op0,
  input  logic [3:0]           op1,
  input  logic [WORD_SIZE-1:0] a0,
  input  logic [WORD_SIZE-1:0] b0,
  input  logic [WORD_SIZE-1:0] a1,
  input  logic [WORD_SIZE-1:0] b1,
  output logic                 grant0,
  output logic                 grant1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 rcmp
);
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic                 last_grant_q, last_grant_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic                 rvalid0_q, rvalid0_d;
  logic                 rvalid1_q, rvalid1_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 rcmp_q, rcmp_d;

  logic [WORD_SIZE-1:0] alu_a, alu_b, alu_c;
  logic [3:0]           alu_op;
  logic                 alu_cmp;

  // Grants are gated by reset so nothing is accepted while reset_n is low.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0 && !req1) begin
        grant0 = 1'b1;
      end else if (req1 && !req0) begin
        grant1 = 1'b1;
      end else if (req0 && req1) begin
`ifdef ALU_ARB_PRIO_EN
        if (wait_cnt_q == MAX_WAIT_C) grant1 = 1'b1;
        else                          grant0 = 1'b1;
`else
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
`endif
      end
    end
  end

  // Port 0 drives the ALU whenever port 1 is not granted.
  assign alu_a  = grant1 ? a1  : a0;
  assign alu_b  = grant1 ? b1  : b0;
  assign alu_op = grant1 ? op1 : op0;

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .a       (alu_a),
    .b       (alu_b),
    .op      (alu_op),
    .c       (alu_c),
    .compare (alu_cmp)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant1)      last_grant_d = 1'b1;
    else if (grant0) last_grant_d = 1'b0;

    wait_cnt_d = wait_cnt_q;
    if (!req1 || grant1)            wait_cnt_d = '0;
    else if (wait_cnt_q < MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;

    rvalid0_d = grant0;
    rvalid1_d = grant1;
    rdata_d   = (grant0 || grant1) ? alu_c   : rdata_q;
    rcmp_d    = (grant0 || grant1) ? alu_cmp : rcmp_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata_q      <= '0;
      rcmp_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata_q      <= rdata_d;
      rcmp_q       <= rcmp_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;
  assign rcmp    = rcmp_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vector table, reset corners, then random traffic against a reference model.
// Honours ALU_ARB_PRIO_EN the same way as the design.

module tb_alu_arbiter;
  localparam int MAX_WAIT = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_TCP = 4'd2, OP_XOR = 4'd5,
                         OP_INC = 4'd9, OP_LHI = 4'd11;

  logic clk, reset_n, req0, req1, grant0, grant1, rvalid0, rvalid1, rcmp;
  logic [3:0] op0, op1;
  logic [15:0] a0, b0, a1, b1, rdata;

  int total = 0;
  int bad = 0;

  alu_arbiter #(.WORD_SIZE(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .req0(req0), .req1(req1),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .grant0(grant0), .grant1(grant1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rcmp(rcmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU from plain integer arithmetic; bit 16 is the compare flag.
  function automatic logic [16:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int x, y, r;
    x = a; y = b;
    case (op)
      4'd0: r = x + y;   4'd1: r = x - y;   4'd2: r = -x;
      4'd3: r = x & y;   4'd4: r = x | y;   4'd5: r = x ^ y;
      4'd6: r = ~x;      4'd7: r = x * 2;   4'd8: r = x / 2;
      4'd9: r = x + 1;   4'd10: r = x - 1;  4'd11: r = (y % 256) * 256;
      default: r = 0;
    endcase
    return {(a == b), 16'(r)};
  endfunction

  typedef struct {
    logic r0, r1;
    logic [3:0] o0; logic [15:0] x0, y0;
    logic [3:0] o1; logic [15:0] x1, y1;
    logic g0, g1, v0, v1;
    logic [15:0] d; logic c;
  } vec_t;
  vec_t vecs[10];

  // Reference model state: who won the last tie-relevant grant, and how long port 1 has waited.
  int last_winner;
  int p1_wait;
  logic m_v0, m_v1, m_c;
  logic [15:0] m_d;

  task automatic model_reset();
    last_winner = 1; p1_wait = 0;
    m_v0 = 0; m_v1 = 0; m_d = 0; m_c = 0;
  endtask

  function automatic int pick(input logic r0, input logic r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (!r0 && !r1) return -1;
`ifdef ALU_ARB_PRIO_EN
    return (p1_wait >= MAX_WAIT) ? 1 : 0;
`else
    return (last_winner == 0) ? 1 : 0;
`endif
  endfunction

  task automatic model_step(input int g);
    logic [16:0] res;
    if (g >= 0) last_winner = g;
    if (req1 && g != 1) p1_wait = (p1_wait < MAX_WAIT) ? p1_wait + 1 : MAX_WAIT;
    else p1_wait = 0;
    m_v0 = (g == 0); m_v1 = (g == 1);
    if (g >= 0) begin
      res = (g == 0) ? alu_ref(op0, a0, b0) : alu_ref(op1, a1, b1);
      m_d = res[15:0]; m_c = res[16];
    end
  endtask

  task automatic check_outputs(input string tag, input logic v0, input logic v1, input logic [15:0] d, input logic c);
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'(v0));
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'(v1));
    chk({tag, "_rdata"}, 32'(rdata), 32'(d));
    chk({tag, "_rcmp"}, 32'(rcmp), 32'(c));
  endtask

  logic pend[2];
  logic [3:0] p_op[2];
  logic [15:0] p_a[2], p_b[2];
  int g_exp;

  initial begin
    reset_n = 0; req0 = 1; req1 = 1;
    op0 = OP_ADD; op1 = OP_SUB; a0 = 16'h1111; b0 = 16'h2222; a1 = 16'h3333; b1 = 16'h4444;

    // Reset held two cycles with both requests high.
    repeat (2) begin
      @(negedge clk);
      chk("reset_grant0", 32'(grant0), 0);
      chk("reset_grant1", 32'(grant1), 0);
      @(posedge clk); #1;
      check_outputs("reset", 0, 0, 16'h0000, 0);
    end
    reset_n = 1; req0 = 0; req1 = 0;

    vecs[0] = '{1'b1, 1'b0, OP_ADD, 16'h1234, 16'h0011, OP_ADD, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1245, 1'b0};
    vecs[1] = '{1'b0, 1'b1, OP_ADD, 16'h0, 16'h0, OP_SUB, 16'h00A5, 16'h00A5, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
    for (int i = 2; i < 6; i++) begin
`ifdef ALU_ARB_PRIO_EN
      vecs[i] = '{1'b1, 1'b1, OP_ADD, 16'h0001, 16'h0002, OP_XOR, 16'h00F0, 16'h000F,
                  1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0};
`else
      if (i % 2 == 0)
        vecs[i] = '{1'b1, 1'b1, OP_ADD, 16'h0001, 16'h0002, OP_XOR, 16'h00F0, 16'h000F,
                    1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0};
      else
        vecs[i] = '{1'b1, 1'b1, OP_ADD, 16'h0001, 16'h0002, OP_XOR, 16'h00F0, 16'h000F,
                    1'b0, 1'b1, 1'b0, 1'b1, 16'h00FF, 1'b0};
`endif
    end
    vecs[6] = '{1'b1, 1'b0, OP_INC, 16'hFFFF, 16'hFFFF, OP_ADD, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{1'b1, 1'b0, OP_TCP, 16'h0001, 16'h0000, OP_ADD, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0};
    vecs[8] = '{1'b0, 1'b0, OP_ADD, 16'h0007, 16'h0007, OP_ADD, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    vecs[9] = '{1'b0, 1'b1, OP_ADD, 16'h0, 16'h0, OP_LHI, 16'h0005, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1200, 1'b0};

    foreach (vecs[i]) begin
      req0 = vecs[i].r0; op0 = vecs[i].o0; a0 = vecs[i].x0; b0 = vecs[i].y0;
      req1 = vecs[i].r1; op1 = vecs[i].o1; a1 = vecs[i].x1; b1 = vecs[i].y1;
      @(negedge clk);
      chk($sformatf("vec%0d_grant0", i), 32'(grant0), 32'(vecs[i].g0));
      chk($sformatf("vec%0d_grant1", i), 32'(grant1), 32'(vecs[i].g1));
      @(posedge clk); #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].v0, vecs[i].v1, vecs[i].d, vecs[i].c);
      $display("vec %0d: req=%b%b grant=%b%b rvalid=%b%b rdata=%h rcmp=%b",
               i, req0, req1, grant0, grant1, rvalid0, rvalid1, rdata, rcmp);
    end

    // Grant issued, then reset lands on the capturing edge: result must be dropped.
    req0 = 1; op0 = OP_LHI; a0 = 16'h0000; b0 = 16'h00AB; req1 = 0;
    @(negedge clk);
    chk("midflight_grant0", 32'(grant0), 1);
    #1 reset_n = 0;
    @(posedge clk); #1;
    check_outputs("midflight", 0, 0, 16'h0000, 0);
    req0 = 0;
    @(posedge clk); #1;
    reset_n = 1;
    $display("midflight reset: rvalid=%b%b rdata=%h", rvalid0, rvalid1, rdata);
    model_reset();

`ifdef ALU_ARB_PRIO_EN
    // Both ports held: four port-0 grants, then the starved port 1 wins, then port 0 again.
    req0 = 1; op0 = OP_ADD; a0 = 16'h0010; b0 = 16'h0001;
    req1 = 1; op1 = OP_SUB; a1 = 16'h0020; b1 = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_grant1", i), 32'(grant1), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve%0d_grant0", i), 32'(grant0), (i == 4) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      $display("starve %0d: grant0=%b grant1=%b rdata=%h", i, rvalid0, rvalid1, rdata);
    end
    req0 = 0; req1 = 0;
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    model_reset();
`endif

    // Random traffic: requests stay up with stable operands until granted, occasionally dropped.
    pend[0] = 0; pend[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k]) begin
          if ($urandom_range(1) == 1) begin
            pend[k] = 1;
            p_op[k] = 4'($urandom_range(15));
            p_a[k] = 16'($urandom);
            p_b[k] = ($urandom_range(3) == 0) ? p_a[k] : 16'($urandom);
          end
        end else if ($urandom_range(9) == 0) begin
          pend[k] = 0;
        end
      end
      req0 = pend[0]; op0 = p_op[0]; a0 = p_a[0]; b0 = p_b[0];
      req1 = pend[1]; op1 = p_op[1]; a1 = p_a[1]; b1 = p_b[1];
      @(negedge clk);
      g_exp = pick(req0, req1);
      chk("rand_grant0", 32'(grant0), 32'(g_exp == 0));
      chk("rand_grant1", 32'(grant1), 32'(g_exp == 1));
      model_step(g_exp);
      if (g_exp >= 0) pend[g_exp] = 0;
      @(posedge clk); #1;
      check_outputs("rand", m_v0, m_v1, m_d, m_c);
      if (g_exp >= 0)
        $display("txn %0d: port=%0d rdata=%h rcmp=%b expect=%h/%b", cyc, g_exp, rdata, rcmp, m_d, m_c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
